// File: rtl/nack_crc8_framer.sv
// Streaming CRC-8 (poly 0x1D) framer: forwards 16-bit words with one register stage, appends a CRC tail beat.
// Output register stalls under m_ready backpressure, s_ready drops while stalled or while the tail is pending. Optional macro: NACK_CRC8_ERRINJ_EN.
module nack_crc8_framer #(
  parameter logic [7:0] CRC_INIT = 8'h00,
  parameter int         LEN_W    = 16
) (
`ifdef NACK_CRC8_ERRINJ_EN
  input  logic             errinj,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_sop,
  input  logic             s_eop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic             m_sop,
  output logic             m_eop,
  output logic [1:0]       m_keep,
  output logic [7:0]       crc_out,
  output logic [LEN_W-1:0] frame_len,
  output logic             crc_done,
  output logic             proto_err
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  // 16-bit parallel CRC-8 next-state function, s_data[15] shifted in first.
  function automatic logic [7:0] ipbase_crc8_w16(input logic [15:0] din, input logic [7:0] cyc);
    logic [7:0] c;
    c = cyc;
    for (int i = 15; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ (((c[7] ^ din[i]) == 1'b1) ? 8'h1D : 8'h00);
    end
    return c;
  endfunction

  state_t           state_q;
  logic [7:0]       crc_q;
  logic [LEN_W-1:0] len_q;
  logic             m_valid_q, m_sop_q, m_eop_q;
  logic [15:0]      m_data_q;
  logic [1:0]       m_keep_q;
  logic [7:0]       crc_out_q;
  logic [LEN_W-1:0] frame_len_q;
  logic             crc_done_q, proto_err_q;

  logic             out_free, acc;
  logic [7:0]       crc_d, tail_crc;
  logic [LEN_W-1:0] len_d;

  always_comb begin
    out_free = !m_valid_q || m_ready;
    s_ready  = out_free && (state_q != TAIL);
    acc      = s_valid && s_ready;
    crc_d    = ipbase_crc8_w16(s_data, s_sop ? CRC_INIT : crc_q);
    len_d    = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + {{(LEN_W-1){1'b0}}, 1'b1};
  end

`ifdef NACK_CRC8_ERRINJ_EN
  logic inj_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inj_q <= 1'b0;
    else if (acc && s_sop)
      inj_q <= errinj;
  end
  // Injection only corrupts what leaves the block; the running CRC stays true.
  assign tail_crc = crc_q ^ {7'd0, inj_q};
`else
  assign tail_crc = crc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 16'h0000;
      m_sop_q     <= 1'b0;
      m_eop_q     <= 1'b0;
      m_keep_q    <= 2'b00;
      crc_out_q   <= CRC_INIT;
      frame_len_q <= '0;
      crc_done_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      crc_done_q  <= 1'b0;
      proto_err_q <= 1'b0;
      if (out_free)
        m_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc) begin
            if (s_sop) begin
              m_valid_q <= 1'b1;
              m_data_q  <= s_data;
              m_sop_q   <= 1'b1;
              m_eop_q   <= 1'b0;
              m_keep_q  <= 2'b11;
              crc_q     <= crc_d;
              len_q     <= {{(LEN_W-1){1'b0}}, 1'b1};
              state_q   <= s_eop ? TAIL : DATA;
            end else begin
              proto_err_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (acc) begin
            m_valid_q   <= 1'b1;
            m_data_q    <= s_data;
            m_sop_q     <= s_sop;
            m_eop_q     <= 1'b0;
            m_keep_q    <= 2'b11;
            crc_q       <= crc_d;
            // A stray SOP abandons the open frame and starts a fresh one.
            len_q       <= s_sop ? {{(LEN_W-1){1'b0}}, 1'b1} : len_d;
            proto_err_q <= s_sop;
            if (s_eop)
              state_q <= TAIL;
          end
        end
        TAIL: begin
          if (out_free) begin
            m_valid_q   <= 1'b1;
            m_data_q    <= {tail_crc, 8'h00};
            m_sop_q     <= 1'b0;
            m_eop_q     <= 1'b1;
            m_keep_q    <= 2'b10;
            crc_out_q   <= tail_crc;
            frame_len_q <= len_q;
            crc_done_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_sop     = m_sop_q;
  assign m_eop     = m_eop_q;
  assign m_keep    = m_keep_q;
  assign crc_out   = crc_out_q;
  assign frame_len = frame_len_q;
  assign crc_done  = crc_done_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_nack_crc8_framer.sv
// Randomized bench for nack_crc8_framer against a frame-level reference model.
module tb_nack_crc8_framer;
  localparam logic [7:0] INIT = 8'h00;

  logic        clk, rst_n;
  logic        s_valid, s_ready, s_sop, s_eop;
  logic [15:0] s_data;
  logic        m_valid, m_ready, m_sop, m_eop;
  logic [15:0] m_data;
  logic [1:0]  m_keep;
  logic [7:0]  crc_out;
  logic [15:0] frame_len;
  logic        crc_done, proto_err;
`ifdef NACK_CRC8_ERRINJ_EN
  logic        errinj_v;
`endif

  nack_crc8_framer #(.CRC_INIT(INIT), .LEN_W(16)) dut (
`ifdef NACK_CRC8_ERRINJ_EN
    .errinj(errinj_v),
`endif
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop),
    .m_keep(m_keep), .crc_out(crc_out), .frame_len(frame_len),
    .crc_done(crc_done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dat;
    logic        sop, eop;
    logic [1:0]  keep;
    logic [7:0]  crc;
    int          len;
  } beat_t;

  beat_t       expq[$];
  logic [15:0] fr[$];
  bit          in_frame, fr_inj;
  int          exp_perr, exp_done, got_perr, got_done;
  int          errors, checks;
  int          mode;      // 0: m_ready=1, 1: random, 2: m_ready=0
  bit          chk_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CRC of the whole frame as one MSB-first bit stream divided by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] frame_crc();
    logic [7:0] r;
    logic [15:0] w;
    r = INIT;
    foreach (fr[k]) begin
      w = fr[k];
      for (int b = 15; b >= 0; b--) begin
        if ((r[7] ^ w[b]) == 1'b1) r = {r[6:0], 1'b0} ^ 8'h1D;
        else                       r = {r[6:0], 1'b0};
      end
    end
    return r;
  endfunction

  task automatic push_beat(input logic [15:0] d, input logic sop, input logic eop,
                           input logic [1:0] keep, input logic [7:0] c, input int len);
    beat_t b;
    b.dat = d; b.sop = sop; b.eop = eop; b.keep = keep; b.crc = c; b.len = len;
    expq.push_back(b);
  endtask

  task automatic model_accept(input logic [15:0] d, input logic sop, input logic eop, input bit inj);
    logic [7:0] c;
    int n;
    if (sop) begin
      if (in_frame) exp_perr++;
      fr.delete();
      fr.push_back(d);
      fr_inj   = inj;
      in_frame = 1;
      push_beat(d, 1'b1, 1'b0, 2'b11, 8'h00, 0);
    end else if (!in_frame) begin
      exp_perr++;
      return;
    end else begin
      fr.push_back(d);
      push_beat(d, 1'b0, 1'b0, 2'b11, 8'h00, 0);
    end
    if (eop) begin
      c = frame_crc() ^ {7'd0, fr_inj};
      n = (fr.size() > 65535) ? 65535 : fr.size();
      push_beat({c, 8'h00}, 1'b0, 1'b1, 2'b10, c, n);
      exp_done++;
      in_frame = 0;
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic sop, input logic eop, input bit inj);
    int n;
    bit ok;
    n = 0; ok = 0;
    @(negedge clk);
    s_valid = 1; s_data = d; s_sop = sop; s_eop = eop;
`ifdef NACK_CRC8_ERRINJ_EN
    errinj_v = inj;
`endif
    while (n < 200) begin
      #1;
      if (s_ready) begin ok = 1; break; end
      @(negedge clk);
      n++;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      model_accept(d, sop, eop, inj);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); s_valid = 0; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk); s_valid = 0; #3; n++;
    end while ((expq.size() != 0 || m_valid) && n < 500);
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    case (mode)
      0: m_ready = 1'b1;
      2: m_ready = 1'b0;
      default: m_ready = ($urandom % 4) != 0;
    endcase
  end

  bit          hold_prev;
  logic [20:0] prev_out;
  always @(negedge clk) begin
    beat_t b;
    #2;
    if (rst_n && chk_en) begin
      if (crc_done) got_done++;
      if (proto_err) got_perr++;
      if (hold_prev) chk("bp_stable", {11'd0, prev_out}, {11'd0, m_valid, m_data, m_sop, m_eop, m_keep});
      if (m_valid && !m_ready) chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) chk("unexpected_beat", {16'd0, m_data}, 32'hFFFFFFFF);
        else begin
          b = expq.pop_front();
          chk("beat", {12'd0, m_data, m_sop, m_eop, m_keep}, {12'd0, b.dat, b.sop, b.eop, b.keep});
          if (b.eop) begin
            chk("crc_out", {24'd0, crc_out}, {24'd0, b.crc});
            chk("frame_len", {16'd0, frame_len}, b.len);
          end
        end
      end
      hold_prev = m_valid && !m_ready;
      prev_out  = {m_valid, m_data, m_sop, m_eop, m_keep};
    end else begin
      hold_prev = 0;
    end
  end

  initial begin
    int p0, d0, len, kind;
    logic sop, eop;
    bit inj;
    clk = 0; rst_n = 0; s_valid = 0; s_data = 0; s_sop = 0; s_eop = 0; m_ready = 0;
`ifdef NACK_CRC8_ERRINJ_EN
    errinj_v = 0;
`endif
    mode = 0; chk_en = 0; errors = 0; checks = 0;
    exp_perr = 0; exp_done = 0; got_perr = 0; got_done = 0; in_frame = 0;
    #12;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_fields", {12'd0, m_data, m_sop, m_eop, m_keep}, 32'd0);
    chk("rst_crc_out", {24'd0, crc_out}, {24'd0, INIT});
    chk("rst_frame_len", {16'd0, frame_len}, 32'd0);
    chk("rst_pulses", {30'd0, crc_done, proto_err}, 32'd0);
    @(negedge clk); rst_n = 1; chk_en = 1;

    fr.delete(); fr.push_back(16'h0001);
    chk("model_pin_1w", {24'd0, frame_crc()}, 32'h1D);
    fr.push_back(16'h0000);
    chk("model_pin_2w", {24'd0, frame_crc()}, 32'h8F);
    fr.delete();

    send_word(16'h0001, 1, 1, 0);
    drain();
    chk("t1_crc", {24'd0, crc_out}, 32'h1D);
    chk("t1_len", {16'd0, frame_len}, 32'd1);
    chk("t1_done_pulses", got_done, 32'd1);

    send_word(16'h0001, 1, 0, 0);
    send_word(16'h0000, 0, 1, 0);
    @(posedge clk);
    mode = 2;
    repeat (5) begin
      @(negedge clk); s_valid = 0; #3;
      chk("bp_tail", {14'd0, m_valid, m_eop, m_data}, {14'd0, 2'b11, 16'h8F00});
      chk("bp_tail_s_ready", {31'd0, s_ready}, 32'd0);
    end
    mode = 0;
    drain();
    chk("t2_crc", {24'd0, crc_out}, 32'h8F);
    chk("t2_len", {16'd0, frame_len}, 32'd2);

    for (int i = 0; i < 4; i++) send_word(16'h0000, i == 0, i == 3, 0);
    @(negedge clk); s_valid = 0; #1;
    chk("bubble_low", {31'd0, s_ready}, 32'd0);
    @(negedge clk); #1;
    chk("bubble_one_cycle", {31'd0, s_ready}, 32'd1);
    drain();
    chk("t3_crc", {24'd0, crc_out}, 32'h00);
    chk("t3_len", {16'd0, frame_len}, 32'd4);

    p0 = got_perr; d0 = got_done;
    send_word(16'h1234, 0, 0, 0);
    @(negedge clk); s_valid = 0; #3;
    chk("idle_drop_m_valid", {31'd0, m_valid}, 32'd0);
    chk("idle_drop_perr", got_perr, p0 + 1);
    send_word(16'h1234, 1, 0, 0);
    send_word(16'h0001, 1, 1, 0);
    drain();
    chk("restart_perr", got_perr, p0 + 2);
    chk("restart_crc", {24'd0, crc_out}, 32'h1D);
    chk("restart_len", {16'd0, frame_len}, 32'd1);
    chk("restart_one_tail", got_done, d0 + 1);

`ifdef NACK_CRC8_ERRINJ_EN
    send_word(16'h0001, 1, 1, 1);
    drain();
    chk("errinj_crc", {24'd0, crc_out}, 32'h1C);
    send_word(16'h0001, 1, 1, 0);
    drain();
    chk("errinj_clear_crc", {24'd0, crc_out}, 32'h1D);
`endif

    send_word(16'h5555, 1, 0, 0);
    @(negedge clk); s_valid = 0; #1;
    rst_n = 0; #1;
    chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_crc_out", {24'd0, crc_out}, {24'd0, INIT});
    chk_en = 0; expq.delete(); in_frame = 0; fr.delete();
    @(negedge clk); rst_n = 1; chk_en = 1;
    repeat (3) @(negedge clk);
    chk("arst_no_tail", {31'd0, m_valid}, 32'd0);

    mode = 1;
    for (int f = 0; f < 300; f++) begin
      len  = $urandom_range(1, 6);
      kind = $urandom % 20;
      inj  = ($urandom % 2) == 1;
`ifndef NACK_CRC8_ERRINJ_EN
      inj  = 0;
`endif
      for (int i = 0; i < len; i++) begin
        sop = (i == 0) && (kind != 0);
        if (kind == 1 && i > 0 && i == len / 2) sop = 1;
        eop = (i == len - 1);
        send_word(16'($urandom), sop, eop, inj);
        if ($urandom % 4 == 0) idle($urandom_range(1, 2));
      end
    end
    mode = 0;
    drain();
    repeat (2) @(negedge clk);
    chk("final_perr_count", got_perr, exp_perr);
    chk("final_done_count", got_done, exp_done);
    chk("final_queue_empty", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nack_crc8_framer.md
Name: nack_crc8_framer

Overview:
- Streaming CRC-8 framer that sits directly upstream of the 16-bit-parallel CRC-8 next-state function, ipbase_crc8_w16, in the NACK generator datapath.
- Accepts NACK frames as 16-bit words with a valid/ready handshake and holds the running CRC register that feeds the CRC function.
- Forwards each frame with one register stage of latency, then appends one tail beat carrying the CRC-8 (polynomial 0x1D).

Parameters:
- CRC_INIT, 8'h00: CRC register seed loaded on every SOP word.
- LEN_W, 16: width of the frame word counter; the counter saturates.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  16  input word; s_data[15] is the first bit on the wire.
- s_sop  in  1  first word of frame.
- s_eop  in  1  last word of frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  16  output beat.
- m_sop  out  1  first beat of frame.
- m_eop  out  1  last beat of frame (the CRC tail only).
- m_keep  out  2  valid bytes: 2'b11 for data beats, 2'b10 for the tail.
- crc_out  out  8  CRC of the last completed frame.
- frame_len  out  LEN_W  number of data words in the last completed frame.
- crc_done  out  1  one-cycle pulse when the tail beat is loaded.
- proto_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset values: all outputs 0, except crc_out = CRC_INIT. Internal state: crc_q = CRC_INIT, len_q = 0, FSM in IDLE.
- out_free = !m_valid || m_ready. The output register loads only when out_free is high.
- s_ready = out_free && (state != TAIL). s_ready is combinational and has no dependence on s_valid.
- CRC step on each accepted word:
  - crc_q <= f(din = s_data, cyc = s_sop ? CRC_INIT : crc_q).
  - f is ipbase_crc8_w16 with din[15:0] and cyc[7:0] used; dout[7:0] is the next CRC.
  - All other bits of the CRC function's ports are tied to 0 and ignored.
- FSM:
  - IDLE:
    - Accepted word with s_sop: forwarded with m_sop=1, m_keep=11, len_q=1; go to DATA. If s_eop is also set, go to TAIL instead (single-word frame).
    - Accepted word without s_sop: consumed and dropped, proto_err pulses, no output.
  - DATA:
    - Accepted word: forwarded with m_sop=0, m_eop=0; len_q increments, saturating at all-ones.
    - If the word has s_eop, go to TAIL.
    - If the word has s_sop, proto_err pulses and the frame restarts: CRC re-seeded, len_q=1, word forwarded with m_sop=1. The previous frame gets no tail.
  - TAIL:
    - No input is accepted.
    - When out_free: load m_data={crc_q,8'h00}, m_keep=10, m_eop=1, m_sop=0.
    - Same cycle: crc_out<=crc_q, frame_len<=len_q, crc_done pulses; go to IDLE.
- Latency and throughput:
  - An accepted word appears on m_* in the next cycle.
  - With m_ready held high, the tail beat is driven the cycle after the EOP word.
  - An N-word frame costs N+1 output beats and one input bubble.
- Backpressure: when m_valid && !m_ready, all m_* outputs hold stable and s_ready=0.
- The data path is never combinational from s_* to m_*.
- Asynchronous reset mid-frame: the frame is abandoned, outputs clear immediately, and no tail is emitted.

Optional Feature:
- Macro: NACK_CRC8_ERRINJ_EN.
- With the macro defined:
  - Adds input port errinj (1 bit), sampled at the accepted SOP word of each frame.
  - If errinj was 1 at SOP, that frame's tail CRC byte and crc_out have bit 0 inverted; crc_q itself is unaffected.
- Without the macro: the port is absent and the CRC is always correct.

Test Plan:
- Single-word frame 16'h0001, sop=eop=1, CRC_INIT=0, m_ready=1:
  - Beats {0001, sop, keep=11} then {1D00, eop, keep=10}.
  - crc_out=0x1D, frame_len=1, crc_done one pulse.
- Two-word frame 0001, 0000:
  - Tail data 16'h8F00, crc_out=0x8F, frame_len=2.
- All-zero 4-word frame with CRC_INIT=0:
  - Tail 16'h0000, frame_len=4.
  - s_ready low for exactly one cycle after the EOP is accepted.
- m_ready held low 5 cycles during the tail of the two-word frame:
  - m_data stays 8F00, m_eop=1 and s_ready=0 throughout.
  - Beat completes when m_ready rises; no duplicate beat.
- Framing errors:
  - Non-SOP word in IDLE: dropped, proto_err pulses, m_valid stays 0.
  - SOP word in DATA: proto_err pulses, the new frame's tail CRC is computed from CRC_INIT.
- With NACK_CRC8_ERRINJ_EN, errinj=1 on the frame 0001:
  - Tail 16'h1C00, crc_out=0x1C.
  - The next frame, with errinj=0, gives the correct CRC.
